// File: rtl/result_display_driver_pkg.sv
// rtl/result_display_driver_pkg.sv - shared state encoding and 7-segment constants
// Contents:
//   state_t    : update FSM states (IDLE, CONV, UPDATE)
//   DIG_W      : width of the scan digit index (4 digits)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_MINUS  : only segment g lit
//   seg_digit(): BCD digit 0-9 to active-low gfedcba pattern
package result_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam int DIG_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/result_display_driver_if.sv
// rtl/result_display_driver_if.sv - result bus between calculator FSM and display driver
// Signals:
//   load      : 1-cycle strobe, sampled in IDLE
//   value     : result byte
//   is_signed : value is two's complement
//   busy      : conversion in progress
//   done      : 1-cycle pulse when display registers update
//   bcd_out   : {hundreds, tens, ones} of displayed magnitude
//   neg       : displayed value is negative
// Modports: master = result producer, slave = display driver.
interface result_display_driver_if;
    logic        load;
    logic [7:0]  value;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        neg;

    modport master (
        output load, value, is_signed,
        input  busy, done, bcd_out, neg
    );

    modport slave (
        input  load, value, is_signed,
        output busy, done, bcd_out, neg
    );
endinterface

// File: rtl/result_display_driver_bin2bcd_serial.sv
// rtl/result_display_driver_bin2bcd_serial.sv - serial shift-add-3 binary to BCD converter
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : load bin and begin an 8-cycle conversion
//   bin        : 8-bit unsigned input
//   bcd        : {hundreds, tens, ones}; final once the last shift has taken effect
//   done       : high during the last shift cycle, so the caller can act on the
//                edge that completes the conversion
module bin2bcd_serial (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    // {hundreds, tens, ones, binary}; binary bits shift out of the top into the BCD field.
    logic [19:0] sr;
    logic [19:0] sr_adj;
    logic [3:0]  iter;
    logic        running;

    always_comb begin
        sr_adj = sr;
        if (sr[11:8]  >= 4'd5) sr_adj[11:8]  = sr[11:8]  + 4'd3;
        if (sr[15:12] >= 4'd5) sr_adj[15:12] = sr[15:12] + 4'd3;
        if (sr[19:16] >= 4'd5) sr_adj[19:16] = sr[19:16] + 4'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            iter    <= '0;
            running <= 1'b0;
        end else if (start) begin
            sr      <= {12'd0, bin};
            iter    <= '0;
            running <= 1'b1;
        end else if (running) begin
            sr <= {sr_adj[18:0], 1'b0};
            if (iter == 4'd7) begin
                iter    <= '0;
                running <= 1'b0;
            end else begin
                iter <= iter + 4'd1;
            end
        end
    end

    assign bcd  = sr[19:8];
    assign done = running && (iter == 4'd7);

endmodule

// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - result capture, BCD conversion and 4-digit 7-segment scan
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : result bus (slave side): load/value/is_signed in, busy/done/bcd_out/neg out
//   seg        : active-low segments, seg[0]=a .. seg[6]=g
//   an         : active-low one-hot digit enables, an[0]=ones
// Parameter REFRESH_DIV: clk cycles each digit stays enabled (min 2).
module result_display_driver
    import result_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    result_display_driver_if.slave bus,
    output logic [6:0]             seg,
    output logic [3:0]             an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t      state, state_nx;
    logic        conv_start;
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic        neg_pending;
    logic [7:0]  magnitude;

    logic [CNT_W-1:0] scan_cnt;
    logic [DIG_W-1:0] dig_idx, dig_idx_nx;

    // Two's complement negate on 8 bits; 0x80 maps to 128, which still fits.
    assign magnitude = (bus.is_signed && bus.value[7]) ? (~bus.value + 8'd1) : bus.value;

    bin2bcd_serial u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (magnitude),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        state_nx   = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    conv_start = 1'b1;
                    state_nx   = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) state_nx = ST_UPDATE;
            end
            ST_UPDATE: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bus.done    <= 1'b0;
            bus.bcd_out <= '0;
            bus.neg     <= 1'b0;
            neg_pending <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.done <= (state == ST_UPDATE);
            if (conv_start) neg_pending <= bus.is_signed && bus.value[7];
            if (state == ST_UPDATE) begin
                bus.bcd_out <= conv_bcd;
                bus.neg     <= neg_pending;
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);

    function automatic logic [6:0] digit_seg(input logic [DIG_W-1:0] idx,
                                             input logic [11:0]      bcd,
                                             input logic             is_neg);
        logic [6:0] s;
        case (idx)
            2'd0:    s = seg_digit(bcd[3:0]);
            2'd1:    s = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg_digit(bcd[7:4]);
            2'd2:    s = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_digit(bcd[11:8]);
            default: s = is_neg ? SEG_MINUS : SEG_BLANK;
        endcase
        return s;
    endfunction

    // an/seg are computed from the index the scan is moving to, so both change on
    // the same edge as the index itself.
    assign dig_idx_nx = (scan_cnt == CNT_LAST) ? dig_idx + 1'b1 : dig_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            an       <= 4'b1110;
            seg      <= 7'b1000000;
        end else begin
            scan_cnt <= (scan_cnt == CNT_LAST) ? '0 : scan_cnt + 1'b1;
            dig_idx  <= dig_idx_nx;
            an       <= ~(4'b0001 << dig_idx_nx);
            seg      <= digit_seg(dig_idx_nx, bus.bcd_out, bus.neg);
        end
    end

endmodule

// File: tb/tb_result_display_driver.sv
// tb/tb_result_display_driver.sv - self-checking bench for result_display_driver
module tb_result_display_driver;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg;
    logic [3:0] an;

    always #5 clk = ~clk;

    result_display_driver_if bus ();

    result_display_driver #(.REFRESH_DIV(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .seg   (seg),
        .an    (an)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Clock edges since reset was released; the scanned digit is derived from it.
    int k;
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    logic [6:0] seg_tab [10];
    int         shown_mag;
    bit         shown_neg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int d);
        int h, t, o;
        h = shown_mag / 100;
        t = (shown_mag / 10) % 10;
        o = shown_mag % 10;
        case (d)
            0:       return seg_tab[o];
            1:       return (h == 0 && t == 0) ? 7'b1111111 : seg_tab[t];
            2:       return (h == 0) ? 7'b1111111 : seg_tab[h];
            default: return shown_neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic check_display(input int n);
        int d;
        logic [3:0] exp_an;
        repeat (n) begin
            @(negedge clk);
            d = (k / R) % 4;
            exp_an = 4'b1111;
            exp_an[d] = 1'b0;
            check("an", {28'd0, an}, {28'd0, exp_an});
            check("seg", {25'd0, seg}, {25'd0, model_seg(d)});
        end
    endtask

    task automatic run_conv(input logic [7:0] v, input bit s, input bit intrude);
        int mag;
        bit ng;
        int exp_bcd;
        ng  = s && (v >= 8'd128);
        mag = ng ? 256 - int'(v) : int'(v);
        exp_bcd = (mag / 100) * 256 + ((mag / 10) % 10) * 16 + (mag % 10);
        @(negedge clk);
        bus.load = 1'b1; bus.value = v; bus.is_signed = s;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) bus.load = 1'b0;
            if (intrude && i == 3) begin
                bus.load = 1'b1; bus.value = 8'h63; bus.is_signed = 1'b0;
            end
            if (intrude && i == 4) bus.load = 1'b0;
            check("busy_conv", {31'd0, bus.busy}, 32'd1);
            check("done_early", {31'd0, bus.done}, 32'd0);
        end
        @(negedge clk);
        check("busy_end", {31'd0, bus.busy}, 32'd0);
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        check("bcd_out", {20'd0, bus.bcd_out}, exp_bcd);
        check("neg", {31'd0, bus.neg}, {31'd0, ng});
        shown_mag = mag;
        shown_neg = ng;
        @(negedge clk);
        check("done_single", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        shown_mag = 0;
        shown_neg = 1'b0;
        bus.load = 1'b0; bus.value = 8'h00; bus.is_signed = 1'b0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hE);
        check("rst_seg", {25'd0, seg}, 32'h40);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_bcd", {20'd0, bus.bcd_out}, 32'd0);
        check("rst_neg", {31'd0, bus.neg}, 32'd0);
        reset = 1'b0;
        check_display(24);

        run_conv(8'hFF, 1'b0, 1'b0); check_display(16);
        run_conv(8'h80, 1'b1, 1'b0); check_display(16);
        run_conv(8'hFB, 1'b1, 1'b0); check_display(16);
        run_conv(8'hFB, 1'b0, 1'b0); check_display(16);
        run_conv(8'h0C, 1'b0, 1'b1); check_display(16);
        run_conv(8'h63, 1'b0, 1'b0); check_display(16);
        run_conv(8'h00, 1'b1, 1'b0); check_display(16);

        for (int r = 0; r < 16; r++) begin
            run_conv(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            check_display(5);
        end

        // Reset in the middle of a conversion of 0xC8.
        @(negedge clk);
        bus.load = 1'b1; bus.value = 8'hC8; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_bcd", {20'd0, bus.bcd_out}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_an", {28'd0, an}, 32'hE);
        check("mid_rst_seg", {25'd0, seg}, 32'h40);
        @(negedge clk);
        reset = 1'b0;
        shown_mag = 0;
        shown_neg = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, bus.done}, 32'd0);
            check("bcd_after_rst", {20'd0, bus.bcd_out}, 32'd0);
        end
        check_display(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
